// File: rtl/lfsr15_check_pkg.sv
// Shared definitions for the 15-bit LFSR (x^15 + x^14 + 1) pattern checker
// and any generator that reuses its expansion logic.
package lfsr15_check_pkg;

    // Length of the LFSR state, in sequence bits.
    localparam int LFSR15_BITS = 15;

    // Feedback taps: s[n] = s[n-TAP_HI] ^ s[n-TAP_LO].
    localparam int TAP_HI = 15;
    localparam int TAP_LO = 14;

    // Checker state.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Number of bits needed to hold a popcount of a word of the given width.
    function automatic int popcnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage : lfsr15_check_pkg

// File: rtl/lfsr15_expand.sv
// Combinational LFSR expansion: from the last 15 sequence bits (bit 0 oldest),
// produce the next DataBits bits of the x^15 + x^14 + 1 sequence. Bit 0 of the
// output is the first (oldest) new bit. Shared with the pattern generator.
module lfsr15_expand
    import lfsr15_check_pkg::*;
#(
    parameter int DataBits = 32
) (
    input  logic [LFSR15_BITS-1:0] state_i,
    output logic [DataBits-1:0]    bits_o
);

    localparam int ExtW = DataBits + LFSR15_BITS;

    // Unroll the recurrence over the whole word; each new bit depends only on
    // bits already placed further down the vector.
    always_comb begin
        logic [ExtW-1:0] ext_v;
        ext_v                    = '0;
        ext_v[LFSR15_BITS-1:0]   = state_i;
        for (int n = LFSR15_BITS; n < ExtW; n++) begin
            ext_v[n] = ext_v[n-TAP_HI] ^ ext_v[n-TAP_LO];
        end
        bits_o = ext_v[ExtW-1:LFSR15_BITS];
    end

endmodule : lfsr15_expand

// File: rtl/lfsr15_check.sv
// Self-synchronising checker for the 15-bit LFSR link-test pattern.
// SEARCH: rebuilds the reference from received data until LockCount
// consecutive words match. LOCKED: free-runs its own prediction so received
// errors never corrupt it, and accumulates saturating word/bit error counts.
// DataBits must be at least 15 so a single word reseeds the full state.
module lfsr15_check
    import lfsr15_check_pkg::*;
#(
    parameter int DataBits    = 32,
    parameter int LockCount   = 4,
    parameter int UnlockCount = 4,
    parameter int CountBits   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DataBits-1:0]           data_in,
    input  logic                          valid,
    input  logic                          clear,
    output logic                          locked,
    output logic                          err_word,
    output logic [$clog2(DataBits+1)-1:0] err_bits,
    output logic [CountBits-1:0]          word_err_count,
    output logic [CountBits-1:0]          bit_err_count
);

    localparam int ErrW = popcnt_width(DataBits);
    // Sum width wide enough for both operands plus a carry, so clamping is exact
    // even when a single word's popcount exceeds the counter range.
    localparam int SumW = ((CountBits > ErrW) ? CountBits : ErrW) + 1;
    localparam logic [CountBits-1:0] CntMax = '1;
    localparam logic [7:0] LockCnt8   = 8'(LockCount);
    localparam logic [7:0] UnlockCnt8 = 8'(UnlockCount);

    // Popcount of a mismatch vector.
    function automatic logic [ErrW-1:0] popcount(input logic [DataBits-1:0] v);
        logic [ErrW-1:0] c;
        c = '0;
        for (int i = 0; i < DataBits; i++) begin
            c = c + ErrW'(v[i]);
        end
        return c;
    endfunction

    state_e                  state_q, state_d;
    logic                    have_ref_q, have_ref_d;
    logic [LFSR15_BITS-1:0]  ref_q, ref_d;
    logic [7:0]              good_cnt_q, good_cnt_d;
    logic [7:0]              bad_cnt_q, bad_cnt_d;
    logic                    locked_q, locked_d;
    logic                    err_word_q, err_word_d;
    logic [ErrW-1:0]         err_bits_q, err_bits_d;
    logic [CountBits-1:0]    word_cnt_q, word_cnt_d;
    logic [CountBits-1:0]    bit_cnt_q, bit_cnt_d;

    logic [DataBits-1:0]     expected_s;
    logic [DataBits-1:0]     mismatch_s;
    logic [ErrW-1:0]         mm_pop_s;
    logic                    match_s;
    logic [7:0]              good_inc_s;
    logic [7:0]              bad_inc_s;
    logic [SumW-1:0]         bit_sum_s;

    lfsr15_expand #(
        .DataBits (DataBits)
    ) u_expand (
        .state_i (ref_q),
        .bits_o  (expected_s)
    );

    // Compare the received word with the prediction and pre-compute increments.
    always_comb begin
        mismatch_s = data_in ^ expected_s;
        mm_pop_s   = popcount(mismatch_s);
        match_s    = (mismatch_s == '0);
        good_inc_s = good_cnt_q + 8'd1;
        bad_inc_s  = bad_cnt_q + 8'd1;
        bit_sum_s  = SumW'(bit_cnt_q) + SumW'(mm_pop_s);
    end

    // Next-state, reference update, error pulse and counter logic.
    always_comb begin
        state_d    = state_q;
        have_ref_d = have_ref_q;
        ref_d      = ref_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_word_d = 1'b0;
        err_bits_d = '0;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (valid) begin
            case (state_q)
                SEARCH: begin
                    ref_d = data_in[DataBits-1 -: LFSR15_BITS];
                    if (!have_ref_q) begin
                        have_ref_d = 1'b1;
                    end else if (match_s) begin
                        if (good_inc_s == LockCnt8) begin
                            state_d    = LOCKED;
                            bad_cnt_d  = 8'd0;
                            good_cnt_d = 8'd0;
                        end else begin
                            good_cnt_d = good_inc_s;
                        end
                    end else begin
                        good_cnt_d = 8'd0;
                    end
                end
                LOCKED: begin
                    // Free-run: the prediction, not the received word, feeds the reference.
                    ref_d = expected_s[DataBits-1 -: LFSR15_BITS];
                    if (!match_s) begin
                        err_word_d = 1'b1;
                        err_bits_d = mm_pop_s;
                        if (word_cnt_q != CntMax) begin
                            word_cnt_d = word_cnt_q + CountBits'(1);
                        end else begin
                            word_cnt_d = CntMax;
                        end
                        if (bit_sum_s > SumW'(CntMax)) begin
                            bit_cnt_d = CntMax;
                        end else begin
                            bit_cnt_d = bit_sum_s[CountBits-1:0];
                        end
                        if (bad_inc_s == UnlockCnt8) begin
                            state_d    = SEARCH;
                            good_cnt_d = 8'd0;
                            bad_cnt_d  = 8'd0;
                            ref_d      = data_in[DataBits-1 -: LFSR15_BITS];
                        end else begin
                            bad_cnt_d = bad_inc_s;
                        end
                    end else begin
                        bad_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = 8'd0;
                    bad_cnt_d  = 8'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Host clear wins over any increment made in the same cycle.
        if (clear) begin
            word_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            word_cnt_d = word_cnt_d;
            bit_cnt_d  = bit_cnt_d;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            have_ref_q <= 1'b0;
            ref_q      <= '0;
            good_cnt_q <= 8'd0;
            bad_cnt_q  <= 8'd0;
            locked_q   <= 1'b0;
            err_word_q <= 1'b0;
            err_bits_q <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            have_ref_q <= have_ref_d;
            ref_q      <= ref_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            locked_q   <= locked_d;
            err_word_q <= err_word_d;
            err_bits_q <= err_bits_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign locked         = locked_q;
    assign err_word       = err_word_q;
    assign err_bits       = err_bits_q;
    assign word_err_count = word_cnt_q;
    assign bit_err_count  = bit_cnt_q;

endmodule : lfsr15_check

// File: tb/tb_lfsr15_check.sv
// Bench for lfsr15_check: two instances (32-bit and 4-bit counters) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_lfsr15_check;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data = '0;
    logic          valid = 1'b0;
    logic          clear = 1'b0;

    logic          locked_b, err_word_b;
    logic [5:0]    err_bits_b;
    logic [31:0]   wcnt_b, bcnt_b;
    logic          locked_s, err_word_s;
    logic [5:0]    err_bits_s;
    logic [3:0]    wcnt_s, bcnt_s;

    always #5 clk = ~clk;

    lfsr15_check #(.DataBits(DW), .LockCount(4), .UnlockCount(4), .CountBits(32)) u_dut (
        .clk(clk), .rst(rst), .data_in(data), .valid(valid), .clear(clear),
        .locked(locked_b), .err_word(err_word_b), .err_bits(err_bits_b),
        .word_err_count(wcnt_b), .bit_err_count(bcnt_b)
    );

    lfsr15_check #(.DataBits(DW), .LockCount(4), .UnlockCount(4), .CountBits(4)) u_small (
        .clk(clk), .rst(rst), .data_in(data), .valid(valid), .clear(clear),
        .locked(locked_s), .err_word(err_word_s), .err_bits(err_bits_s),
        .word_err_count(wcnt_s), .bit_err_count(bcnt_s)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next 32 sequence bits after the given 15 (bit 0 oldest), by the recurrence.
    function automatic logic [31:0] predict(input logic [14:0] r);
        bit s [0:46];
        logic [31:0] w;
        for (int i = 0; i < 15; i++) s[i] = r[i];
        for (int n = 15; n < 47; n++) s[n] = s[n-15] ^ s[n-14];
        for (int k = 0; k < 32; k++) w[k] = s[15+k];
        return w;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural model state.
    bit          m_locked, m_have;
    logic [14:0] m_ref;
    int          m_good, m_bad;
    longint      m_wtot, m_btot;
    bit          e_err_word;
    int          e_err_bits;
    logic [31:0] m_pred, m_mm;

    // Model update on every accepting edge (and on reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked = 0; m_have = 0; m_ref = '0; m_good = 0; m_bad = 0;
            m_wtot = 0; m_btot = 0; e_err_word = 0; e_err_bits = 0;
        end else begin
            e_err_word = 0;
            e_err_bits = 0;
            if (valid) begin
                m_pred = predict(m_ref);
                m_mm   = data ^ m_pred;
                if (!m_locked) begin
                    if (!m_have) m_have = 1;
                    else if (m_mm == 0) begin
                        m_good++;
                        if (m_good == 4) begin m_locked = 1; m_bad = 0; m_good = 0; end
                    end else m_good = 0;
                    m_ref = data[31:17];
                end else begin
                    m_ref = m_pred[31:17];
                    if (m_mm != 0) begin
                        e_err_word = 1;
                        e_err_bits = $countones(m_mm);
                        m_wtot++;
                        m_btot += $countones(m_mm);
                        m_bad++;
                        if (m_bad == 4) begin
                            m_locked = 0; m_good = 0; m_bad = 0; m_ref = data[31:17];
                        end
                    end else m_bad = 0;
                end
            end
            if (clear) begin m_wtot = 0; m_btot = 0; end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",      locked_b,   m_locked);
            check("err_word",    err_word_b, e_err_word);
            check("err_bits",    err_bits_b, e_err_bits);
            check("word_cnt",    wcnt_b,     sat(m_wtot, 64'hFFFF_FFFF));
            check("bit_cnt",     bcnt_b,     sat(m_btot, 64'hFFFF_FFFF));
            check("s_locked",    locked_s,   m_locked);
            check("s_err_word",  err_word_s, e_err_word);
            check("s_err_bits",  err_bits_s, e_err_bits);
            check("s_word_cnt",  wcnt_s,     sat(m_wtot, 15));
            check("s_bit_cnt",   bcnt_s,     sat(m_btot, 15));
        end
    end

    logic [14:0] gen_ref = 15'h5555;

    task automatic gen(output logic [31:0] w);
        w = predict(gen_ref);
        gen_ref = w[31:17];
    endtask

    // Drive one cycle of inputs; returns 2 time units after the accepting edge.
    task automatic step(input logic v, input logic [31:0] w, input logic c);
        valid = v; data = w; clear = c;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] w;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_locked", locked_b, 0);
        check("rst_wcnt",   wcnt_b,   0);
        check("rst_errw",   err_word_b, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Acquire: word0 seeds, words 1-4 match, locked after word4.
        for (int i = 0; i < 5; i++) begin
            gen(w);
            if (i == 0) check("pin_word0", w, 32'h1000_3FFF);
            step(1'b1, w, 1'b0);
            if (i == 3) check("lock_early", locked_b, 0);
            if (i == 4) check("lock_after5", locked_b, 1);
        end
        for (int i = 0; i < 1000; i++) begin gen(w); step(1'b1, w, 1'b0); end
        check("clean_wcnt", wcnt_b, 0);
        check("clean_bcnt", bcnt_b, 0);

        // Single bit-7 flip, no propagation afterwards.
        gen(w); step(1'b1, w ^ 32'h0000_0080, 1'b0);
        check("flip_errw", err_word_b, 1);
        check("flip_errb", err_bits_b, 1);
        check("flip_wcnt", wcnt_b, 1);
        check("flip_bcnt", bcnt_b, 1);
        for (int i = 0; i < 20; i++) begin gen(w); step(1'b1, w, 1'b0); end
        check("flip_after_errw", err_word_b, 0);
        check("flip_after_wcnt", wcnt_b, 1);

        // Four inverted words drop lock; five clean words relock.
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            gen(w); step(1'b1, ~w, 1'b0);
            check("inv_errb", err_bits_b, 32);
        end
        check("inv_unlock", locked_b, 0);
        check("inv_wcnt", wcnt_b, 4);
        check("inv_bcnt", bcnt_b, 128);
        check("inv_s_bcnt", bcnt_s, 15);
        for (int i = 0; i < 5; i++) begin
            gen(w); step(1'b1, w, 1'b0);
            if (i == 3) check("relock_early", locked_b, 0);
            if (i == 4) check("relock", locked_b, 1);
        end

        // Random valid gaps on a clean locked stream.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin gen(w); step(1'b1, w, 1'b0); end
            else step(1'b0, $urandom, 1'b0);
        end
        check("gap_locked", locked_b, 1);
        check("gap_wcnt", wcnt_b, 4);

        // Saturation with 20 single-bit errors, spaced by clean words.
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            gen(w); step(1'b1, w ^ (32'h1 << $urandom_range(0, 31)), 1'b0);
            gen(w); step(1'b1, w, 1'b0);
        end
        check("sat_s_wcnt", wcnt_s, 15);
        check("sat_s_bcnt", bcnt_s, 15);
        check("sat_wcnt", wcnt_b, 20);
        check("sat_bcnt", bcnt_b, 20);
        gen(w); step(1'b1, w ^ 32'h0000_0004, 1'b1);
        check("clr_errw", err_word_b, 1);
        check("clr_s_wcnt", wcnt_s, 0);
        check("clr_s_bcnt", bcnt_s, 0);
        check("clr_wcnt", wcnt_b, 0);

        // Asynchronous reset mid-lock, between clock edges.
        gen(w); step(1'b1, w ^ 32'h0001_0000, 1'b0);
        check("pre_rst_wcnt", wcnt_b, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_locked", locked_b, 0);
        check("arst_wcnt", wcnt_b, 0);
        check("arst_bcnt", bcnt_b, 0);
        check("arst_s_wcnt", wcnt_s, 0);
        valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gen(w); step(1'b1, w, 1'b0);
            if (i == 3) check("rst_relock_early", locked_b, 0);
            if (i == 4) check("rst_relock", locked_b, 1);
        end
        for (int i = 0; i < 10; i++) begin gen(w); step(1'b1, w, 1'b0); end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lfsr15_check

// File: doc/lfsr15_check.md
Name: lfsr15_check

Overview:
Self-synchronising checker for the 15-bit maximal-length LFSR pattern (x^15+x^14+1) that the team's pattern generator produces, DataBits per word.
- Bit 0 of each word is the oldest bit.
- Recovers the sequence from received data and locks after consecutive clean words.
- Once locked, free-runs its own prediction and counts word and bit errors.
- Sits at the sink end of a wavetrace link-test path, with counters read by the host.

Parameters:
DataBits, 32, word width; must be >= 15.
LockCount, 4, consecutive matching words needed to lock (1..255).
UnlockCount, 4, consecutive mismatching words that drop lock (1..255).
CountBits, 32, width of both saturating error counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
data_in  in  DataBits  received pattern word
valid  in  1  data_in qualifier; words are only consumed when high
clear  in  1  synchronous clear of both error counters
locked  out  1  checker is in LOCKED state
err_word  out  1  one-cycle pulse: the previous accepted word mismatched while locked
err_bits  out  $clog2(DataBits+1)  popcount of the mismatch for the word flagged by err_word; 0 otherwise
word_err_count  out  CountBits  saturating count of errored words
bit_err_count  out  CountBits  saturating count of errored bits

Behaviour:
Reset (async assert, sync release) values:
- locked=0, err_word=0, err_bits=0, both counters=0.
- state=SEARCH, have_ref=0, ref_reg=0, good_cnt=0, bad_cnt=0.

Prediction (combinational):
- Input: ref_reg[14:0], the last 15 sequence bits.
- Extend with s[n]=s[n-15]^s[n-14] for DataBits new bits; expected = extended bits [DataBits+14:15].
- mismatch = data_in ^ expected.

Cycles with valid=0 change no state; err_word and err_bits read 0 on the following cycle.

SEARCH, valid=1:
- ref_reg <= data_in[DataBits-1:DataBits-15].
- If have_ref=0: set have_ref; no compare.
- Otherwise, on match: good_cnt++. When good_cnt reaches LockCount, go to LOCKED, set bad_cnt=0, and assert locked on the next cycle.
- On mismatch: good_cnt=0.
- Errors are never counted in SEARCH.

LOCKED, valid=1:
- ref_reg <= expected[DataBits-1:DataBits-15]. The checker free-runs, so a received error never propagates into the prediction.
- On mismatch: err_word=1 and err_bits=popcount on the next cycle; word_err_count+1; bit_err_count+popcount; bad_cnt++.
- When bad_cnt reaches UnlockCount: go to SEARCH, good_cnt=0, ref_reg <= data_in top 15, have_ref stays 1.
- On match: bad_cnt=0.

Latency: all outputs are registered, one cycle after the accepting edge.

Counters:
- Saturate at all-ones; never wrap.
- bit add is computed at CountBits+1 width, then clamped.

clear:
- Zeroes both counters.
- Takes priority over a simultaneous error increment; err_word/err_bits still pulse for that error.
- Does not affect state, lock, or ref_reg.

Asynchronous reset mid-operation returns to the reset values immediately; resync then needs 1+LockCount valid words.

An all-zero ref_reg predicts all zeros; a stuck-zero input can therefore lock. This is accepted behaviour, visible to the host, and not masked.

Decomposition:
- Shared package/header:
  - LFSR15_BITS=15
  - tap constants (15, 14)
  - state encoding: SEARCH=1'b0, LOCKED=1'b1
  - popcount width function
- One natural sub-module: lfsr15_expand.
  - Combinational: DataBits param; 15-bit state in; extended bits out.
  - Reusable by the generator.
- The popcount stays local.

Test Plan:
- Generator seed 15'h5555, DataBits=32, valid every cycle after reset: word0 seeds; words 1-4 match; locked=1 the cycle after word4 is accepted; both counters stay 0 over 1000 words.
- Locked, flip bit 7 of one word: err_word pulses once, err_bits=1, word_err_count=1, bit_err_count=1; all following words are clean (no propagation).
- Locked, invert 4 consecutive words: err_bits=32 each, counters 4/128, locked=0 after the fourth; the next 5 clean words relock (1 seed + 4 matches).
- Random valid gaps (~50% duty) on a locked stream: no errors, lock held; err_word never asserts during gaps.
- CountBits=4, inject 20 single-bit errors: both counters stick at 15. clear asserted with an error in the same cycle: counters=0, err_word still pulses.
- Assert rst asynchronously mid-lock (between edges): locked and counters drop to 0 without a clock edge; after release, relock takes exactly 5 valid words.
